// File: rtl/usb_ep_pkg.sv
// Endpoint-side types and helpers for the IN transaction sequencer.
package usb_ep_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecide,
    StSendHs,
    StSendData,
    StWaitTx,
    StWaitAck,
    StFinish
  } InTxState_t;

  // Indices beyond the mask width are never isochronous.
  function automatic logic isIsoEp(input logic [14:0] mask, input int unsigned idx);
    return |(mask & (15'd1 << idx));
  endfunction

endpackage

// File: rtl/usb_packet_pkg.sv
// USB packet identifier constants used by the IN transaction sequencer.
package usb_packet_pkg;

  localparam int unsigned DATA_0_1_TOGGLE_OFFSET = 3;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = PID_DATA0 | (4'b0001 << DATA_0_1_TOGGLE_OFFSET);
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

endpackage

// File: rtl/usb_ep_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits; a global clear beats any flip.
module usb_ep_toggle_bank #(
  parameter int unsigned EP_CNT = 4
) (
  input  logic              clk12,
  input  logic              rst,
  input  logic              clear,
  input  logic [EP_CNT-1:0] flip,
  output logic [EP_CNT-1:0] toggle
);

  logic [EP_CNT-1:0] toggle_q;

  always_ff @(posedge clk12) begin
    if (rst || clear) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ flip;
    end
  end

  assign toggle = toggle_q;

endmodule

// File: rtl/usb_ep_in_tx_sequencer.sv
// IN transaction sequencer: answers an IN token with DATA/NAK/STALL, streams the FIFO
// payload to the serializer and commits or rolls back the FIFO pop on the host handshake.
module usb_ep_in_tx_sequencer
  import usb_ep_pkg::*;
  import usb_packet_pkg::*;
#(
  parameter int unsigned  EP_CNT       = 4,
  parameter int unsigned  MAX_PKT_SIZE = 64,
  parameter logic [14:0]  ISO_EP_MASK  = '0,
  parameter int unsigned  ACK_TIMEOUT  = 24,
  localparam int unsigned EP_IDX_WID   = (EP_CNT > 1) ? $clog2(EP_CNT) : 1
) (
  input  logic                  clk12_i,
  input  logic                  rst_i,
  input  logic                  transStart_i,
  input  logic [EP_IDX_WID-1:0] epSel_i,
  input  logic [EP_CNT-1:0]     epHalt_i,
  input  logic                  resetDataToggle_i,
  input  logic [EP_CNT-1:0]     EP_IN_dataAvailable_i,
  input  logic [8*EP_CNT-1:0]   EP_IN_data_i,
  output logic [EP_CNT-1:0]     EP_IN_popData_o,
  output logic [EP_CNT-1:0]     EP_IN_popTransDone_o,
  output logic [EP_CNT-1:0]     EP_IN_popTransSuccess_o,
  output logic                  txStart_o,
  output logic [3:0]            txPID_o,
  output logic [7:0]            txData_o,
  output logic                  txDataValid_o,
  input  logic                  txDataReady_i,
  input  logic                  txDone_i,
  input  logic                  hsValid_i,
  input  logic                  hsIsAck_i,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_SIZE + 1);
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  InTxState_t            state_q, state_d;
  logic [EP_IDX_WID-1:0] ep_q, ep_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  commit_q, commit_d;
  logic                  tx_start_q, tx_start_d;
  logic [3:0]            pid_q, pid_d;

  logic              sel_halt, sel_avail, sel_toggle, sel_iso;
  logic [7:0]        sel_data;
  logic [EP_CNT-1:0] ep_onehot, toggle, flip;
  logic              pkt_full, data_valid, byte_accept, in_finish;

  // An out-of-range endpoint index matches nothing and therefore reads as halted.
  always_comb begin
    sel_halt   = 1'b1;
    sel_avail  = 1'b0;
    sel_toggle = 1'b0;
    sel_data   = '0;
    ep_onehot  = '0;
    for (int unsigned i = 0; i < EP_CNT; i++) begin
      if (ep_q == EP_IDX_WID'(i)) begin
        sel_halt     = epHalt_i[i];
        sel_avail    = EP_IN_dataAvailable_i[i];
        sel_toggle   = toggle[i];
        sel_data     = EP_IN_data_i[8*i +: 8];
        ep_onehot[i] = 1'b1;
      end
    end
  end

  assign sel_iso     = isIsoEp(ISO_EP_MASK, 32'(ep_q));
  assign pkt_full    = (32'(cnt_q) >= MAX_PKT_SIZE);
  // No payload byte in the cycle txStart_o is up: the serializer is still taking the PID.
  assign data_valid  = (state_q == StSendData) && !tx_start_q && sel_avail && !pkt_full;
  assign byte_accept = data_valid && txDataReady_i;
  assign in_finish   = (state_q == StFinish);

  always_comb begin
    state_d    = state_q;
    ep_d       = ep_q;
    cnt_d      = cnt_q;
    tmr_d      = tmr_q;
    commit_d   = commit_q;
    tx_start_d = 1'b0;
    pid_d      = pid_q;
    unique case (state_q)
      StIdle: begin
        if (transStart_i) begin
          ep_d    = epSel_i;
          state_d = StDecide;
        end
      end
      StDecide: begin
        tx_start_d = 1'b1;
        if (sel_halt) begin
          pid_d   = PID_STALL;
          state_d = StSendHs;
        end else if (!sel_avail) begin
          pid_d   = PID_NAK;
          state_d = StSendHs;
        end else begin
          pid_d   = (sel_toggle && !sel_iso) ? PID_DATA1 : PID_DATA0;
          state_d = StSendData;
        end
      end
      StSendHs: begin
        if (txDone_i) state_d = StIdle;
      end
      StSendData: begin
        if (byte_accept) cnt_d = cnt_q + CNT_W'(1);
        if (!tx_start_q && (pkt_full || !sel_avail)) state_d = StWaitTx;
      end
      StWaitTx: begin
        if (txDone_i) begin
          if (sel_iso) begin
            commit_d = 1'b1;
            state_d  = StFinish;
          end else begin
            tmr_d   = TMR_W'(ACK_TIMEOUT);
            state_d = StWaitAck;
          end
        end
      end
      StWaitAck: begin
        if (hsValid_i) begin
          commit_d = hsIsAck_i;
          state_d  = StFinish;
        end else if (tmr_q <= TMR_W'(1)) begin
          commit_d = 1'b0;
          state_d  = StFinish;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      StFinish: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk12_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ep_q       <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      commit_q   <= 1'b0;
      tx_start_q <= 1'b0;
      pid_q      <= '0;
    end else begin
      state_q    <= state_d;
      ep_q       <= ep_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      commit_q   <= commit_d;
      tx_start_q <= tx_start_d;
      pid_q      <= pid_d;
    end
  end

  assign flip = (in_finish && commit_q && !sel_iso) ? ep_onehot : '0;

  usb_ep_toggle_bank #(
    .EP_CNT(EP_CNT)
  ) u_toggle_bank (
    .clk12  (clk12_i),
    .rst    (rst_i),
    .clear  (resetDataToggle_i),
    .flip   (flip),
    .toggle (toggle)
  );

  assign txStart_o               = tx_start_q;
  assign txPID_o                 = pid_q;
  assign txDataValid_o           = data_valid;
  assign txData_o                = (state_q == StSendData) ? sel_data : '0;
  assign EP_IN_popData_o         = byte_accept ? ep_onehot : '0;
  assign EP_IN_popTransDone_o    = in_finish ? ep_onehot : '0;
  assign EP_IN_popTransSuccess_o = (in_finish && commit_q) ? ep_onehot : '0;
  assign busy_o                  = (state_q != StIdle);

endmodule

// File: tb/tb_usb_ep_in_tx_sequencer.sv
// Bench for usb_ep_in_tx_sequencer: FIFO/serializer/host model with a PID and payload scoreboard.
module tb_usb_ep_in_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        transStart = 1'b0;
  logic [1:0]  epSel = '0;
  logic [3:0]  epHalt = '0;
  logic        resetDataToggle = 1'b0;
  logic [3:0]  epAvail = '0;
  logic [31:0] epData = '0;
  logic [3:0]  popData, popDone, popSucc;
  logic        txStart, txDataValid, busy;
  logic [3:0]  txPID;
  logic [7:0]  txData;
  logic        txDataReady = 1'b0;
  logic        txDone = 1'b0;
  logic        hsValid = 1'b0;
  logic        hsIsAck = 1'b0;

  // Second instance with 3 endpoints to reach an out-of-range endpoint index.
  logic        ts3 = 1'b0;
  logic [1:0]  sel3 = '0;
  logic        txDone3 = 1'b0;
  logic [2:0]  pop3, done3, succ3;
  logic        txStart3, txValid3, busy3;
  logic [3:0]  pid3;
  logic [7:0]  txData3;

  always #5 clk = ~clk;

  usb_ep_in_tx_sequencer #(
    .EP_CNT(4), .MAX_PKT_SIZE(64), .ISO_EP_MASK(15'h0008), .ACK_TIMEOUT(24)
  ) u_dut (
    .clk12_i(clk), .rst_i(rst), .transStart_i(transStart), .epSel_i(epSel),
    .epHalt_i(epHalt), .resetDataToggle_i(resetDataToggle),
    .EP_IN_dataAvailable_i(epAvail), .EP_IN_data_i(epData),
    .EP_IN_popData_o(popData), .EP_IN_popTransDone_o(popDone),
    .EP_IN_popTransSuccess_o(popSucc), .txStart_o(txStart), .txPID_o(txPID),
    .txData_o(txData), .txDataValid_o(txDataValid), .txDataReady_i(txDataReady),
    .txDone_i(txDone), .hsValid_i(hsValid), .hsIsAck_i(hsIsAck), .busy_o(busy)
  );

  usb_ep_in_tx_sequencer #(
    .EP_CNT(3), .MAX_PKT_SIZE(64), .ISO_EP_MASK(15'h0000), .ACK_TIMEOUT(24)
  ) u_dut3 (
    .clk12_i(clk), .rst_i(rst), .transStart_i(ts3), .epSel_i(sel3),
    .epHalt_i(3'b000), .resetDataToggle_i(1'b0),
    .EP_IN_dataAvailable_i(3'b111), .EP_IN_data_i(24'hC3C2C1),
    .EP_IN_popData_o(pop3), .EP_IN_popTransDone_o(done3),
    .EP_IN_popTransSuccess_o(succ3), .txStart_o(txStart3), .txPID_o(pid3),
    .txData_o(txData3), .txDataValid_o(txValid3), .txDataReady_i(1'b1),
    .txDone_i(txDone3), .hsValid_i(1'b0), .hsIsAck_i(1'b0), .busy_o(busy3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: committed contents plus a transaction read pointer.
  logic [7:0] fifo_q [4][$];
  int         rd [4];

  // Scoreboard: filled when a token is issued, drained as the DUT emits.
  logic [3:0] exp_pid_q [$];
  logic [7:0] exp_byte_q [$];

  task automatic drive_fifo();
    for (int e = 0; e < 4; e++) begin
      epAvail[e] = (rd[e] < fifo_q[e].size());
      epData[8*e +: 8] = epAvail[e] ? fifo_q[e][rd[e]] : 8'h00;
    end
  endtask

  typedef struct {
    int         ep;
    logic [3:0] halt;
    int         nload;
    logic [7:0] first;
    int         hs;       // 0 ACK, 1 NAK, 2 no handshake
    bit         rdy_tgl;
    bit         extra;    // second token while busy
    bit         rdt;      // resetDataToggle in the commit cycle
    logic [3:0] exp_pid;
    int         exp_bytes;
    bit         exp_done;
    bit         exp_succ;
  } vec_t;

  function automatic vec_t mk(int ep, logic [3:0] halt, int nload, logic [7:0] first, int hs,
                              bit tgl, bit extra, bit rdt, logic [3:0] pid, int nb, bit dn,
                              bit sc);
    vec_t v;
    v.ep = ep; v.halt = halt; v.nload = nload; v.first = first; v.hs = hs;
    v.rdy_tgl = tgl; v.extra = extra; v.rdt = rdt; v.exp_pid = pid; v.exp_bytes = nb;
    v.exp_done = dn; v.exp_succ = sc;
    return v;
  endfunction

  task automatic run_in(input vec_t v, input string tag);
    int   rx_cnt = 0, pop_cnt = 0, done_seen = 0, stray = 0, done_cd = -1, hs_cd = -1;
    int   cyc = 0;
    bit   started = 0, in_data = 0, finished = 0, ready_ph = 0, extra_pend = 0;
    bit   pend_pop = 0, pend_done = 0, pend_succ = 0, succ_seen = 0, is_data;
    logic [3:0] oh = 4'b0001 << v.ep;
    is_data = (v.exp_pid == 4'h3) || (v.exp_pid == 4'hB);
    for (int k = 0; k < v.nload; k++) fifo_q[v.ep].push_back(8'(v.first + k));
    exp_pid_q.delete();
    exp_byte_q.delete();
    exp_pid_q.push_back(v.exp_pid);
    for (int k = 0; k < v.exp_bytes; k++) exp_byte_q.push_back(fifo_q[v.ep][rd[v.ep] + k]);
    @(negedge clk);
    epHalt = v.halt; epSel = 2'(v.ep); transStart = 1'b1; txDataReady = 1'b1;
    drive_fifo();
    while (!finished && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (pend_pop) begin rd[v.ep]++; pend_pop = 0; end
      if (pend_done) begin
        if (pend_succ) for (int k = 0; k < rd[v.ep]; k++) void'(fifo_q[v.ep].pop_front());
        rd[v.ep] = 0;
        pend_done = 0;
      end
      drive_fifo();
      transStart = extra_pend;
      epSel = extra_pend ? 2'd2 : epSel;
      extra_pend = 0;
      resetDataToggle = 1'b0;
      txDataReady = v.rdy_tgl ? ready_ph : 1'b1;
      ready_ph = ~ready_ph;
      txDone = (done_cd == 0);
      if (done_cd >= 0) done_cd--;
      if (txDone && is_data && v.hs != 2) hs_cd = 3;
      hsValid = (hs_cd == 0);
      hsIsAck = hsValid && (v.hs == 0);
      if (hs_cd >= 0) hs_cd--;
      #1;
      if (txStart) begin
        started = 1;
        if (exp_pid_q.size() > 0) check({tag, " pid"}, 32'(txPID), 32'(exp_pid_q.pop_front()));
        else check({tag, " extra txStart"}, 32'(txStart), 32'd0);
        in_data = is_data;
        if (!is_data) done_cd = 3;
        if (v.extra) extra_pend = 1;
      end else if (in_data && !txDataValid) begin
        in_data = 0;
        done_cd = 2;
      end
      if (txDataValid && txDataReady) begin
        rx_cnt++;
        if (exp_byte_q.size() > 0)
          check($sformatf("%s byte%0d", tag, rx_cnt), 32'(txData), 32'(exp_byte_q.pop_front()));
      end
      if (|popData) begin
        if (popData == oh) begin pop_cnt++; pend_pop = 1; end
        else stray++;
      end
      if ((|popSucc) && !(|popDone)) stray++;
      if (|popDone) begin
        done_seen++;
        if (popDone != oh) stray++;
        succ_seen = |(popSucc & oh);
        pend_done = 1;
        pend_succ = succ_seen;
        if (v.rdt) resetDataToggle = 1'b1;
      end
      if (started && !busy) finished = 1;
    end
    check({tag, " completes in bound"}, 32'(finished), 32'd1);
    check({tag, " payload count"}, rx_cnt, v.exp_bytes);
    check({tag, " pop count"}, pop_cnt, v.exp_bytes);
    check({tag, " stray fifo strobes"}, stray, 0);
    check({tag, " trans done count"}, done_seen, v.exp_done ? 1 : 0);
    if (v.exp_done) check({tag, " commit"}, 32'(succ_seen), 32'(v.exp_succ));
    @(negedge clk);
    txDone = 1'b0; hsValid = 1'b0; hsIsAck = 1'b0; epHalt = '0; transStart = 1'b0;
    resetDataToggle = 1'b0;
    if (v.extra) begin
      repeat (3) @(negedge clk);
      check({tag, " token while busy ignored"}, 32'(busy), 32'd0);
    end
  endtask

  vec_t vecs [16];

  initial begin
    bit seen;
    vecs[0]  = mk(1, 4'h0, 3,  8'hA1, 0, 0, 0, 0, 4'h3, 3,  1, 1);
    vecs[1]  = mk(1, 4'h0, 1,  8'hB1, 0, 0, 1, 0, 4'hB, 1,  1, 1);
    vecs[2]  = mk(1, 4'h0, 3,  8'hA1, 2, 0, 0, 0, 4'h3, 3,  1, 0);
    vecs[3]  = mk(1, 4'h0, 0,  8'h00, 0, 0, 0, 0, 4'h3, 3,  1, 1);
    vecs[4]  = mk(1, 4'h0, 0,  8'h00, 0, 0, 0, 0, 4'hA, 0,  0, 0);
    vecs[5]  = mk(0, 4'h0, 0,  8'h00, 0, 0, 0, 0, 4'hA, 0,  0, 0);
    vecs[6]  = mk(0, 4'h1, 2,  8'hC1, 0, 0, 0, 0, 4'hE, 0,  0, 0);
    vecs[7]  = mk(0, 4'h0, 0,  8'h00, 0, 0, 0, 0, 4'h3, 2,  1, 1);
    vecs[8]  = mk(2, 4'h0, 70, 8'h40, 0, 1, 0, 0, 4'h3, 64, 1, 1);
    vecs[9]  = mk(2, 4'h0, 0,  8'h00, 0, 0, 0, 0, 4'hB, 6,  1, 1);
    vecs[10] = mk(3, 4'h0, 2,  8'hD1, 2, 0, 0, 0, 4'h3, 2,  1, 1);
    vecs[11] = mk(3, 4'h0, 1,  8'hD3, 2, 0, 0, 0, 4'h3, 1,  1, 1);
    vecs[12] = mk(1, 4'h0, 2,  8'hE1, 1, 0, 0, 0, 4'hB, 2,  1, 0);
    vecs[13] = mk(1, 4'h0, 0,  8'h00, 0, 0, 0, 1, 4'hB, 2,  1, 1);
    vecs[14] = mk(1, 4'h0, 1,  8'hF1, 0, 0, 0, 0, 4'h3, 1,  1, 1);
    vecs[15] = mk(0, 4'h0, 1,  8'hF2, 0, 0, 0, 0, 4'h3, 1,  1, 1);
    for (int e = 0; e < 4; e++) rd[e] = 0;

    // Reset with a token present: reset must win.
    rst = 1'b1;
    transStart = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset outputs", {popData, popDone, popSucc, txStart, txPID, txData, txDataValid},
          32'd0);
    rst = 1'b0;
    transStart = 1'b0;
    drive_fifo();

    for (int i = 0; i < 16; i++) run_in(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a data packet.
    for (int k = 0; k < 5; k++) fifo_q[1].push_back(8'(8'h50 + k));
    @(negedge clk);
    epSel = 2'd1; transStart = 1'b1; txDataReady = 1'b1;
    drive_fifo();
    @(negedge clk);
    transStart = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (txDataValid) seen = 1;
    end
    check("midpacket valid seen", 32'(seen), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midpacket reset busy", 32'(busy), 32'd0);
    check("midpacket reset outputs",
          {popData, popDone, popSucc, txStart, txPID, txData, txDataValid}, 32'd0);
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin fifo_q[e].delete(); rd[e] = 0; end
    drive_fifo();
    run_in(mk(1, 4'h0, 1, 8'h77, 0, 0, 0, 0, 4'h3, 1, 1, 1), "post-reset");

    // Out-of-range endpoint on the 3-endpoint instance answers STALL.
    @(negedge clk);
    ts3 = 1'b1; sel3 = 2'd3;
    @(negedge clk);
    ts3 = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      #1;
      if (txStart3) begin
        seen = 1;
        check("oor pid", 32'(pid3), 32'hE);
      end
    end
    check("oor txStart seen", 32'(seen), 32'd1);
    check("oor no payload", {pop3, done3, succ3, txValid3}, 32'd0);
    @(negedge clk);
    txDone3 = 1'b1;
    @(negedge clk);
    txDone3 = 1'b0;
    #1;
    check("oor back to idle", 32'(busy3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
